nlc_channel_scheduler: RTL and testbench

Time-shares one NLC (nonlinearity-correction) core between NCH ADC channels. Each channel presents a 21-bit signed sample with a one-cycle ready strobe. The block buffers one sample per channel and grants the NLC round-robin. It issues a single-cycle i_srdyi pulse to the NLC, waits for o_srdyo, and returns o_y tagged with its source channel. It sits between the ADC front-end channel capture and the shared NLC instance.

---
 rtl/nlc_channel_scheduler.sv | 164 ++++++++++++++++
 tb/tb_nlc_channel_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nlc_channel_scheduler.sv
// Round-robin scheduler sharing one NLC core between NCH ADC channels.
// Optional WAIT watchdog enabled by defining NLCS_TIMEOUT_EN.
module nlc_channel_scheduler #(
  parameter int NCH         = 4,
  parameter int CHW         = 2,
  parameter int XW          = 21,
  parameter int YW          = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NCH*XW-1:0] i_x_ch,
  input  logic [NCH-1:0]    i_srdyi_ch,
  input  logic              i_ovr_clr,
  output logic [XW-1:0]     o_nlc_x,
  output logic              o_nlc_srdyi,
  input  logic [YW-1:0]     i_nlc_y,
  input  logic              i_nlc_srdyo,
  output logic [YW-1:0]     o_y,
  output logic [CHW-1:0]    o_y_ch,
  output logic              o_srdyo,
  output logic [NCH-1:0]    o_overrun,
  output logic              o_timeout,
  output logic              o_busy,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

`ifdef NLCS_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int CNTW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_e             state_q, state_d;
  logic [NCH-1:0]     pend_q, pend_d;
  logic [NCH-1:0]     ovr_q, ovr_d;
  logic [XW-1:0]      buf_q [NCH];
  logic [CHW-1:0]     rr_q, rr_d;
  logic [CHW-1:0]     gch_q;
  logic [XW-1:0]      nlc_x_q;
  logic [YW-1:0]      y_q;
  logic [CHW-1:0]     y_ch_q;
  logic [CNTW-1:0]    cnt_q;
  logic               timeout_q, timeout_d;
  logic               grant_vld;
  logic [CHW-1:0]     grant_idx;
  logic [CHW-1:0]     idx;
  logic               timeout_hit;

  // Scan from the highest offset down so the nearest pending channel at or after rr wins.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    if (state_q == ST_IDLE) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        idx = CHW'((int'(rr_q) + i) % NCH);
        if (pend_q[idx]) begin
          grant_vld = 1'b1;
          grant_idx = idx;
        end
      end
    end
  end

  assign rr_d = (grant_idx == CHW'(NCH - 1)) ? '0 : grant_idx + CHW'(1);

  always_comb begin
    pend_d = pend_q;
    ovr_d  = i_ovr_clr ? '0 : ovr_q;
    if (grant_vld) pend_d[grant_idx] = 1'b0;
    // A strobe on the channel being granted this cycle is a fresh request, not an overrun.
    for (int k = 0; k < NCH; k++) begin
      if (i_srdyi_ch[k]) begin
        pend_d[k] = 1'b1;
        if (pend_q[k] && !(grant_vld && (grant_idx == CHW'(k)))) ovr_d[k] = 1'b1;
      end
    end
  end

  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNTW'(TIMEOUT_CYC - 1)) && !i_nlc_srdyo;
  assign timeout_d   = (state_q == ST_WAIT) && timeout_hit;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_vld) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_nlc_srdyo)      state_d = ST_OUT;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_OUT:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_nlc_srdyi = (state_q == ST_ISSUE);
    o_srdyo     = (state_q == ST_OUT);
    o_busy      = (state_q != ST_IDLE);
    o_state     = state_q;
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pend_q    <= '0;
      ovr_q     <= '0;
      rr_q      <= '0;
      gch_q     <= '0;
      nlc_x_q   <= '0;
      y_q       <= '0;
      y_ch_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      // NOTE: the sample buffers are small flop arrays, not RAM, so they are reset to a known 0.
      for (int k = 0; k < NCH; k++) buf_q[k] <= '0;
    end else begin
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      timeout_q <= timeout_d;
      for (int k = 0; k < NCH; k++) begin
        if (i_srdyi_ch[k]) buf_q[k] <= i_x_ch[k*XW +: XW];
      end
      if (grant_vld) begin
        gch_q   <= grant_idx;
        nlc_x_q <= buf_q[grant_idx];
        rr_q    <= rr_d;
      end
      if (state_q == ST_ISSUE)     cnt_q <= '0;
      else if (state_q == ST_WAIT) cnt_q <= cnt_q + CNTW'(1);
      if ((state_q == ST_WAIT) && i_nlc_srdyo) begin
        y_q    <= i_nlc_y;
        y_ch_q <= gch_q;
      end
    end
  end

  assign o_nlc_x   = nlc_x_q;
  assign o_y       = y_q;
  assign o_y_ch    = y_ch_q;
  assign o_overrun = ovr_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_nlc_channel_scheduler.sv
// Directed bench for nlc_channel_scheduler with a latency-10 sign-extending NLC model.
// The watchdog scenario runs only when NLCS_TIMEOUT_EN is defined.
module tb_nlc_channel_scheduler;

  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int XW  = 21;
  localparam int YW  = 32;
  localparam int TO  = 16;

  localparam logic [XW-1:0] XM80 = XW'(-80000);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*XW-1:0] x_ch;
  logic [NCH-1:0]    stb;
  logic              ovr_clr;
  logic [XW-1:0]     nlc_x;
  logic              nlc_srdyi;
  logic [YW-1:0]     nlc_y;
  logic              nlc_srdyo;
  logic [YW-1:0]     y;
  logic [CHW-1:0]    y_ch;
  logic              srdyo;
  logic [NCH-1:0]    overrun;
  logic              timeout;
  logic              busy;
  logic [1:0]        state;

  logic              model_srdyo = 1'b0;
  logic [YW-1:0]     model_y = '0;
  logic              man_srdyo = 1'b0;
  logic [YW-1:0]     man_y = '0;
  bit                nlc_en = 1'b1;
  int                mcnt = 0;
  logic [XW-1:0]     mx = '0;

  int errors = 0;
  int checks = 0;

  logic [YW-1:0]  res_y[$];
  logic [CHW-1:0] res_ch[$];
  logic [XW-1:0]  iss_x[$];
  int             to_cnt = 0;

  assign nlc_srdyo = model_srdyo | man_srdyo;
  assign nlc_y     = model_srdyo ? model_y : man_y;

  always #5 clk = ~clk;

  nlc_channel_scheduler #(
    .NCH(NCH), .CHW(CHW), .XW(XW), .YW(YW), .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_x_ch      (x_ch),
    .i_srdyi_ch  (stb),
    .i_ovr_clr   (ovr_clr),
    .o_nlc_x     (nlc_x),
    .o_nlc_srdyi (nlc_srdyi),
    .i_nlc_y     (nlc_y),
    .i_nlc_srdyo (nlc_srdyo),
    .o_y         (y),
    .o_y_ch      (y_ch),
    .o_srdyo     (srdyo),
    .o_overrun   (overrun),
    .o_timeout   (timeout),
    .o_busy      (busy),
    .o_state     (state)
  );

  // NLC model: answers 10 cycles after the start strobe with x sign-extended.
  always @(negedge clk) begin
    model_srdyo = 1'b0;
    if (!rst_n) begin
      mcnt = 0;
    end else begin
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          model_srdyo = 1'b1;
          model_y     = {{(YW-XW){mx[XW-1]}}, mx};
        end
      end
      if (nlc_srdyi && nlc_en) begin
        mx   = nlc_x;
        mcnt = 10;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (srdyo) begin
        res_y.push_back(y);
        res_ch.push_back(y_ch);
      end
      if (nlc_srdyi) iss_x.push_back(nlc_x);
      if (timeout) to_cnt++;
    end
  end

  function automatic logic [NCH*XW-1:0] pack4(input logic [XW-1:0] a, input logic [XW-1:0] b,
                                               input logic [XW-1:0] c, input logic [XW-1:0] d);
    return {d, c, b, a};
  endfunction

  task automatic clear_logs();
    res_y.delete();
    res_ch.delete();
    iss_x.delete();
    to_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    stb     = '0;
    x_ch    = '0;
    ovr_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic strobe(input logic [NCH-1:0] m, input logic [NCH*XW-1:0] xv);
    @(negedge clk);
    stb  = m;
    x_ch = xv;
    @(negedge clk);
    stb  = '0;
  endtask

  task automatic wait_res(input int n, input int budget, input string name);
    int waited = 0;
    while (res_y.size() < n && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (res_y.size() < n) begin
      errors++;
      $display("FAIL %s_wait: got %0d results expected %0d", name, res_y.size(), n);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string name);
    int waited = 0;
    while (state !== s && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (state !== s) begin
      errors++;
      $display("FAIL %s_state_wait: got %0d expected %0d", name, state, s);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    stb     = '0;
    x_ch    = '0;
    ovr_clr = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if ({nlc_srdyi, srdyo, timeout} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {nlc_srdyi, srdyo, timeout}); end
    checks++; if (overrun !== '0) begin errors++; $display("FAIL reset_overrun: got %b expected 0000", overrun); end
    checks++; if (y !== '0 || y_ch !== '0 || nlc_x !== '0) begin errors++; $display("FAIL reset_data: got y=%h ch=%0d x=%h expected 0", y, y_ch, nlc_x); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_idle_hold: got %0d expected 0", state); end
  endtask

  task automatic test_single();
    do_reset();
    strobe(4'b0100, pack4('0, '0, XM80, '0));
    wait_res(1, 60, "single");
    repeat (3) @(negedge clk);
    checks++; if (iss_x.size() != 1) begin errors++; $display("FAIL single_issue_cnt: got %0d expected 1", iss_x.size()); end
    checks++; if (iss_x.size() > 0 && iss_x[0] !== XM80) begin errors++; $display("FAIL single_nlc_x: got %h expected %h", iss_x[0], XM80); end
    checks++; if (res_y.size() != 1) begin errors++; $display("FAIL single_res_cnt: got %0d expected 1", res_y.size()); end
    checks++; if (res_y.size() > 0 && res_y[0] !== 32'hFFFEC780) begin errors++; $display("FAIL single_y: got %h expected FFFEC780", res_y[0]); end
    checks++; if (res_ch.size() > 0 && res_ch[0] !== 2'd2) begin errors++; $display("FAIL single_ch: got %0d expected 2", res_ch[0]); end
    checks++; if (y !== 32'hFFFEC780) begin errors++; $display("FAIL single_y_hold: got %h expected FFFEC780", y); end
  endtask

  task automatic test_all_four();
    logic [YW-1:0] exp_y [4];
    exp_y[0] = 32'h00000000;
    exp_y[1] = 32'h00009C40;
    exp_y[2] = 32'h0000EA60;
    exp_y[3] = 32'hFFFEC780;
    do_reset();
    strobe(4'b1111, pack4(XW'(0), XW'(40000), XW'(60000), XM80));
    wait_res(4, 200, "all4");
    repeat (5) @(negedge clk);
    checks++; if (res_y.size() != 4) begin errors++; $display("FAIL all4_res_cnt: got %0d expected 4", res_y.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < res_y.size()) begin
        checks++; if (res_ch[i] !== CHW'(i)) begin errors++; $display("FAIL all4_ch%0d: got %0d expected %0d", i, res_ch[i], i); end
        checks++; if (res_y[i] !== exp_y[i]) begin errors++; $display("FAIL all4_y%0d: got %h expected %h", i, res_y[i], exp_y[i]); end
      end
    end
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL all4_overrun: got %b expected 0000", overrun); end
  endtask

  task automatic test_round_robin();
    // Continues from the all-four run: rr points at ch0 after ch3.
    clear_logs();
    strobe(4'b1001, pack4(XW'(10), '0, '0, XW'(13)));
    wait_res(2, 100, "rr_a");
    checks++; if (res_ch.size() >= 2 && {res_ch[0], res_ch[1]} !== {2'd0, 2'd3}) begin errors++; $display("FAIL rr_after_ch3: got %0d,%0d expected 0,3", res_ch[0], res_ch[1]); end
    checks++; if (res_y.size() >= 2 && res_y[1] !== 32'd13) begin errors++; $display("FAIL rr_ch3_y: got %h expected 0000000d", res_y[1]); end
    // Serve ch1 alone, so rr sits at ch2 and the ch0/ch3 contest must wrap to ch3 first.
    clear_logs();
    strobe(4'b0010, pack4('0, XW'(1), '0, '0));
    wait_res(1, 60, "rr_b");
    clear_logs();
    strobe(4'b1001, pack4(XW'(20), '0, '0, XW'(23)));
    wait_res(2, 100, "rr_c");
    checks++; if (res_ch.size() >= 2 && {res_ch[0], res_ch[1]} !== {2'd3, 2'd0}) begin errors++; $display("FAIL rr_wrap: got %0d,%0d expected 3,0", res_ch[0], res_ch[1]); end
  endtask

  task automatic test_overrun();
    do_reset();
    strobe(4'b0001, pack4(XW'(5), '0, '0, '0));
    wait_state(2'd2, 20, "ovr");
    strobe(4'b0010, pack4('0, XW'(100), '0, '0));
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_first_strobe: got %b expected 0000", overrun); end
    // Second strobe coincides with a clear: the new overrun must still stick.
    @(negedge clk);
    stb     = 4'b0010;
    x_ch    = pack4('0, XW'(200), '0, '0);
    ovr_clr = 1'b1;
    @(negedge clk);
    stb     = '0;
    ovr_clr = 1'b0;
    checks++; if (overrun !== 4'b0010) begin errors++; $display("FAIL ovr_flag: got %b expected 0010", overrun); end
    wait_res(2, 100, "ovr");
    checks++; if (res_y.size() >= 2 && res_y[0] !== 32'd5) begin errors++; $display("FAIL ovr_ch0_y: got %h expected 00000005", res_y[0]); end
    checks++; if (res_y.size() >= 2 && (res_ch[1] !== 2'd1 || res_y[1] !== 32'd200)) begin errors++; $display("FAIL ovr_ch1_result: got ch=%0d y=%h expected ch=1 y=000000c8", res_ch[1], res_y[1]); end
    checks++; if (overrun !== 4'b0010) begin errors++; $display("FAIL ovr_sticky: got %b expected 0010", overrun); end
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_clear: got %b expected 0000", overrun); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    strobe(4'b0010, pack4('0, XW'(77), '0, '0));
    wait_res(1, 60, "mid_pre");
    checks++; if (y !== 32'd77 || y_ch !== 2'd1) begin errors++; $display("FAIL mid_pre_result: got y=%h ch=%0d expected y=0000004d ch=1", y, y_ch); end
    clear_logs();
    strobe(4'b0100, pack4('0, '0, XW'(33), '0));
    wait_state(2'd2, 20, "mid");
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL mid_state: got state=%0d busy=%0b expected 0", state, busy); end
    checks++; if (y !== '0 || y_ch !== '0 || nlc_x !== '0) begin errors++; $display("FAIL mid_data: got y=%h ch=%0d x=%h expected 0", y, y_ch, nlc_x); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    repeat (3) @(negedge clk);
    man_y     = 32'h0000007B;
    man_srdyo = 1'b1;
    @(negedge clk);
    man_srdyo = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (res_y.size() != 0) begin errors++; $display("FAIL mid_late_srdyo: got %0d results expected 0", res_y.size()); end
    checks++; if (state !== 2'd0 || y !== '0) begin errors++; $display("FAIL mid_after: got state=%0d y=%h expected 0", state, y); end
  endtask

`ifdef NLCS_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    do_reset();
    nlc_en = 1'b0;
    strobe(4'b0011, pack4(XW'(11), XW'(22), '0, '0));
    wait_state(2'd2, 20, "to");
    while (timeout !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != TO) begin errors++; $display("FAIL to_delay: got %0d cycles expected %0d", n, TO); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL to_idle: got %0d expected 0", state); end
    @(negedge clk);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %0b expected 0", timeout); end
    repeat (3) @(negedge clk);
    checks++; if (iss_x.size() < 2 || iss_x[1] !== XW'(22)) begin errors++; $display("FAIL to_next_grant: got %0d issues expected ch1 x=22", iss_x.size()); end
    checks++; if (res_y.size() != 0 || y !== '0) begin errors++; $display("FAIL to_no_result: got %0d results y=%h expected none", res_y.size(), y); end
    nlc_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_round_robin();
    test_overrun();
    test_reset_midop();
`ifdef NLCS_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
